axi4l_regfile_slave: RTL
========================

// Module: axi4l_regfile_slave
// PURPOSE
//  Synthesizable AXI4-Lite slave that serves a bank of NUM_REGS read/write registers for the
//  bundle's AXI4-Lite masters. Write and read channels run independently. Register contents are
//  exported flat to fabric logic, and a per-register write strobe is provided.
// PARAMETERS
//  DATA_WIDTH  32  AXI data width; must be 32 or 64
//  ADDR_WIDTH  32  AXI address width
//  NUM_REGS    16  number of registers; must be a power of 2, >=2
//  Derived: BYTES=DATA_WIDTH/8, LSB=log2(BYTES), IDX_W=log2(NUM_REGS)
// PORTS
//  aclk       in   1                    clock, all logic on posedge
//  areset     in   1                    synchronous active-high reset
//  awaddr     in   ADDR_WIDTH           write address
//  awprot     in   3                    ignored
//  awvalid    in   1                    write address valid
//  awready    out  1                    write address ready
//  wdata      in   DATA_WIDTH           write data
//  wstrb      in   BYTES                byte enables
//  wvalid     in   1                    write data valid
//  wready     out  1                    write data ready
//  bresp      out  2                    00 OKAY, 10 SLVERR
//  bvalid     out  1                    write response valid
//  bready     in   1                    write response ready
//  araddr     in   ADDR_WIDTH           read address
//  arprot     in   3                    ignored
//  arvalid    in   1                    read address valid
//  arready    out  1                    read address ready
//  rdata      out  DATA_WIDTH           read data
//  rresp      out  2                    00 OKAY, 10 SLVERR
//  rvalid     out  1                    read data valid
//  rready     in   1                    read data ready
//  regs_out   out  NUM_REGS*DATA_WIDTH  register i at [i*DATA_WIDTH +: DATA_WIDTH]
//  wr_strobe  out  NUM_REGS             1-cycle pulse on the cycle after register i is written
// BEHAVIOUR
//  Reset (areset=1 at posedge)
//  - All registers are 0. awready=wready=arready=1; bvalid=rvalid=0; bresp=rresp=00; rdata=0;
//    wr_strobe=0.
//  - Reset mid-transaction drops all latched AW/W/AR state and any pending response without
//    emitting it.
//  Decode
//  - idx = addr[LSB +: IDX_W]. addr[LSB-1:0] is ignored.
//  - An address >= NUM_REGS*BYTES is out of range: resp=10, the write is discarded, the read
//    returns rdata=0.
//  Write FSM: W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP
//  - awready=1 in W_IDLE and W_WAIT_ADDR. wready=1 in W_IDLE and W_WAIT_DATA. bvalid=1 only in
//    W_RESP.
//  - W_IDLE, AW and W handshakes in the same cycle: commit the write at that edge -> W_RESP.
//  - W_IDLE, AW only: latch awaddr -> W_WAIT_DATA. W_IDLE, W only: latch wdata/wstrb ->
//    W_WAIT_ADDR.
//  - W_WAIT_DATA and W_WAIT_ADDR: on the missing handshake, commit -> W_RESP.
//  - W_RESP: bresp is held stable. On bready -> W_IDLE. No new AW/W is accepted until then.
//  - bvalid rises the cycle after the completing handshake. Throughput is at most one write
//    every 2 cycles.
//  - Commit sets wr_strobe[idx]=1 for exactly the next cycle. An out-of-range write produces no
//    strobe.
//  Read FSM: R_IDLE (arready=1), R_RESP (rvalid=1, arready=0)
//  - AR handshake: rdata <= reg[idx] value before any write committing at the same edge;
//    rresp set -> R_RESP.
//  - R_RESP: rdata/rresp are held stable until rready -> R_IDLE.
//  - Read latency is 1 cycle. Throughput is at most one read every 2 cycles.
//  Simultaneous events
//  - A read and a write to the same register committing at the same edge: the read returns
//    the old value.
//  - Write and read channels never stall each other.
// CONFIGURATION
//  AXI4L_REGFILE_WSTRB_EN
//  - Defined: only bytes with wstrb[b]=1 are updated; wstrb=0 still produces OKAY and a strobe.
//  - Undefined: wstrb is ignored and every write updates the full word.
// TESTING
//  1. Reset, then write 0xDEADBEEF to 0x08 (AW and W in the same cycle) -> bvalid next cycle,
//     bresp=00, wr_strobe[2] pulses once, regs_out[2]=0xDEADBEEF. Then read 0x08 ->
//     rdata=0xDEADBEEF.
//  2. W at cycle 0, AW at cycle 3, addr 0x04, data 0x12345678, bready held low 4 cycles ->
//     bvalid stays high and stable; awready=wready=0 until B completes; reg1=0x12345678.
//  3. Write 0xFFFFFFFF to 0x0C, then write 0x000000AA with wstrb=0001 -> with
//     AXI4L_REGFILE_WSTRB_EN reg3=0xFFFFFFAA; without it reg3=0x000000AA.
//  4. Write to 0x40 and read from 0x44 (NUM_REGS=16) -> bresp=10, rresp=10, rdata=0, no
//     wr_strobe, all registers unchanged.
//  5. reg5=0x11, then AR 0x14 and the completing W of a write of 0x22 to 0x14 at the same edge
//     -> rdata=0x11; a subsequent read returns 0x22.
//  6. Assert areset while in W_WAIT_DATA and R_RESP -> next cycle bvalid=rvalid=0, ready
//     signals =1, regs_out=0.

Source files
------------

// File: rtl/axi4l_regfile_slave.sv
// AXI4-Lite slave serving NUM_REGS read/write registers, exported flat with per-register strobes.
// Optional byte-lane writes are enabled by defining AXI4L_REGFILE_WSTRB_EN.
module axi4l_regfile_slave #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]            wr_strobe
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned LSB   = $clog2(BYTES);
  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [1:0] {WIdle, WWaitData, WWaitAddr, WResp} wstate_e;
  typedef enum logic       {RIdle, RResp} rstate_e;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (LSB + IDX_W)) == '0;
  endfunction

  wstate_e                wstate_q, wstate_d;
  rstate_e                rstate_q, rstate_d;
  logic [ADDR_WIDTH-1:0]  awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [BYTES-1:0]       wstrb_q, wstrb_d;
  logic [1:0]             bresp_q, bresp_d;
  logic [1:0]             rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [NUM_REGS-1:0]    strobe_q, strobe_d;
  logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]  regs_d [NUM_REGS];

  logic                   aw_fire, w_fire, ar_fire, commit;
  logic [ADDR_WIDTH-1:0]  c_addr;
  logic [DATA_WIDTH-1:0]  c_data;
  logic [BYTES-1:0]       c_strb;
  logic [IDX_W-1:0]       c_idx;

  assign awready = (wstate_q == WIdle) || (wstate_q == WWaitAddr);
  assign wready  = (wstate_q == WIdle) || (wstate_q == WWaitData);
  assign bvalid  = (wstate_q == WResp);
  assign bresp   = bresp_q;
  assign arready = (rstate_q == RIdle);
  assign rvalid  = (rstate_q == RResp);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign wr_strobe = strobe_q;

  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign ar_fire = arvalid && arready;
  assign c_idx   = c_addr[LSB +: IDX_W];

  always_comb begin
    wstate_d = wstate_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bresp_d  = bresp_q;
    commit   = 1'b0;
    c_addr   = awaddr_q;
    c_data   = wdata_q;
    c_strb   = wstrb_q;
    unique case (wstate_q)
      WIdle: begin
        if (aw_fire && w_fire) begin
          commit   = 1'b1;
          c_addr   = awaddr;
          c_data   = wdata;
          c_strb   = wstrb;
          wstate_d = WResp;
        end else if (aw_fire) begin
          awaddr_d = awaddr;
          wstate_d = WWaitData;
        end else if (w_fire) begin
          wdata_d  = wdata;
          wstrb_d  = wstrb;
          wstate_d = WWaitAddr;
        end
      end
      WWaitData: begin
        if (w_fire) begin
          commit   = 1'b1;
          c_data   = wdata;
          c_strb   = wstrb;
          wstate_d = WResp;
        end
      end
      WWaitAddr: begin
        if (aw_fire) begin
          commit   = 1'b1;
          c_addr   = awaddr;
          wstate_d = WResp;
        end
      end
      WResp: begin
        if (bready) wstate_d = WIdle;
      end
      default: wstate_d = WIdle;
    endcase
    if (commit) bresp_d = in_range(c_addr) ? RespOkay : RespSlverr;
  end

  always_comb begin
    regs_d   = regs_q;
    strobe_d = '0;
    if (commit && in_range(c_addr)) begin
      strobe_d[c_idx] = 1'b1;
`ifdef AXI4L_REGFILE_WSTRB_EN
      for (int b = 0; b < BYTES; b++) begin
        if (c_strb[b]) regs_d[c_idx][b*8 +: 8] = c_data[b*8 +: 8];
      end
`else
      regs_d[c_idx] = c_data;
`endif
    end
  end

  // Reads sample regs_q, so a same-edge write is not yet visible.
  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    unique case (rstate_q)
      RIdle: begin
        if (ar_fire) begin
          rstate_d = RResp;
          if (in_range(araddr)) begin
            rdata_d = regs_q[araddr[LSB +: IDX_W]];
            rresp_d = RespOkay;
          end else begin
            rdata_d = '0;
            rresp_d = RespSlverr;
          end
        end
      end
      RResp: begin
        if (rready) rstate_d = RIdle;
      end
      default: rstate_d = RIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wstate_q <= WIdle;
      rstate_q <= RIdle;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RespOkay;
      rresp_q  <= RespOkay;
      rdata_q  <= '0;
      strobe_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bresp_q  <= bresp_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
      strobe_q <= strobe_d;
      regs_q   <= regs_d;
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_out
    assign regs_out[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
  end

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_inputs;
`ifdef AXI4L_REGFILE_WSTRB_EN
  assign unused_inputs = ^{awprot, arprot, awaddr_q[LSB-1:0], awaddr[LSB-1:0], araddr[LSB-1:0]};
`else
  assign unused_inputs = ^{awprot, arprot, awaddr_q[LSB-1:0], awaddr[LSB-1:0], araddr[LSB-1:0],
                           c_strb};
`endif

endmodule
